// File: rtl/dm_cache_ctrl_pkg.sv
// Shared geometry, field widths and FSM encoding for the direct-mapped cache controller.
package dm_cache_ctrl_pkg;
    localparam int LINES   = 32;
    localparam int WORDS   = 4;
    localparam int MEM_LAT = 2;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int INDEX_W = $clog2(LINES);
    localparam int WORD_W  = $clog2(WORDS);
    localparam int TAG_W   = ADDR_W - INDEX_W - WORD_W - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        FILL   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [TAG_W-1:0]   tag,
                                                    input logic [INDEX_W-1:0] idx,
                                                    input logic [WORD_W-1:0]  wrd);
        return {tag, idx, wrd, 1'b0};
    endfunction
endpackage

// File: rtl/dm_cache_ctrl_cache_array.sv
// Tag/valid/dirty/data storage: asynchronous read, synchronous write, valid/dirty cleared by rst.
module dm_cache_ctrl_cache_array
    import dm_cache_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] index,
    input  logic [WORD_W-1:0]  rd_word,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               we_data,
    input  logic [WORD_W-1:0]  wr_word,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               set_dirty,
    input  logic               we_tag,
    input  logic [TAG_W-1:0]   wr_tag
);
    logic [TAG_W-1:0]  tags  [LINES];
    logic [DATA_W-1:0] words [LINES][WORDS];
    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;

    assign rd_tag   = tags[index];
    assign rd_valid = valid[index];
    assign rd_dirty = dirty[index];
    assign rd_data  = words[index][rd_word];

    // A tag write marks a freshly filled, clean line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (we_tag) begin
                valid[index] <= 1'b1;
                dirty[index] <= 1'b0;
            end else if (set_dirty) begin
                dirty[index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we_tag) begin
            tags[index] <= wr_tag;
        end
        if (we_data) begin
            words[index][wr_word] <= wr_data;
        end
    end
endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller; hits complete in the request
// cycle, misses stall the requester while lines are written back and refilled.
module dm_cache_ctrl
    import dm_cache_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    input  logic        createdump,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_createdump
);
    state_t state;
    state_t state_nxt;
    logic [2:0] cnt;
    logic [2:0] cnt_nxt;
    logic [MEM_LAT-1:0]             ret_vld;
    logic [MEM_LAT-1:0][WORD_W-1:0] ret_word;

    logic [15:1] req_addr;
    logic [15:0] req_data;
    logic        req_rd;
    logic        latch_req;

    logic [TAG_W-1:0]   cur_tag;
    logic [INDEX_W-1:0] cur_index;
    logic [WORD_W-1:0]  cur_word;
    logic [WORD_W-1:0]  arr_word;
    logic [TAG_W-1:0]   arr_tag;
    logic               arr_valid;
    logic               arr_dirty;
    logic [15:0]        arr_rdata;
    logic               we_data;
    logic               set_dirty;
    logic               we_tag;
    logic [WORD_W-1:0]  wr_word;
    logic [15:0]        wr_data;
    logic               hit;
    logic               bad;
    logic               ret_now;

    // Outside IDLE the request fields come from the latch, never from the live inputs.
    assign cur_tag   = (state == IDLE) ? Addr[15:8] : req_addr[15:8];
    assign cur_index = (state == IDLE) ? Addr[7:3]  : req_addr[7:3];
    assign cur_word  = (state == IDLE) ? Addr[2:1]  : req_addr[2:1];
    assign arr_word  = (state == WB) ? cnt[WORD_W-1:0] : cur_word;
    assign hit       = arr_valid && (arr_tag == cur_tag);
    assign bad       = (Addr[0] && (Rd || Wr)) || (Rd && Wr);
    assign ret_now   = ret_vld[MEM_LAT-1];

    assign mem_createdump = createdump;

    dm_cache_ctrl_cache_array u_array (
        .clk       (clk),
        .rst       (rst),
        .index     (cur_index),
        .rd_word   (arr_word),
        .rd_tag    (arr_tag),
        .rd_valid  (arr_valid),
        .rd_dirty  (arr_dirty),
        .rd_data   (arr_rdata),
        .we_data   (we_data),
        .wr_word   (wr_word),
        .wr_data   (wr_data),
        .set_dirty (set_dirty),
        .we_tag    (we_tag),
        .wr_tag    (cur_tag)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch_req = 1'b0;
        Done      = 1'b0;
        Stall     = 1'b0;
        CacheHit  = 1'b0;
        err       = 1'b0;
        DataOut   = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        we_data   = 1'b0;
        set_dirty = 1'b0;
        we_tag    = 1'b0;
        wr_word   = cur_word;
        wr_data   = (state == IDLE) ? DataIn : req_data;
        case (state)
            IDLE: begin
                if (Rd || Wr) begin
                    if (bad) begin
                        err  = 1'b1;
                        Done = 1'b1;
                    end else if (hit) begin
                        Done     = 1'b1;
                        CacheHit = 1'b1;
                        if (Rd) begin
                            DataOut = arr_rdata;
                        end else begin
                            we_data   = 1'b1;
                            set_dirty = 1'b1;
                        end
                    end else begin
                        Stall     = 1'b1;
                        latch_req = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = (arr_valid && arr_dirty) ? WB : FILL;
                    end
                end
            end
            WB: begin
                // Tag is still the victim's until the refill completes.
                Stall     = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = word_addr(arr_tag, cur_index, cnt[WORD_W-1:0]);
                mem_wdata = arr_rdata;
                if (cnt[WORD_W-1:0] == 2'd3) begin
                    cnt_nxt   = '0;
                    state_nxt = FILL;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            FILL: begin
                Stall = 1'b1;
                if (!cnt[2]) begin
                    mem_rd   = 1'b1;
                    mem_addr = word_addr(cur_tag, cur_index, cnt[WORD_W-1:0]);
                    cnt_nxt  = cnt + 3'd1;
                end
                if (ret_now) begin
                    we_data = 1'b1;
                    wr_word = ret_word[MEM_LAT-1];
                    wr_data = mem_rdata;
                    if (ret_word[MEM_LAT-1] == 2'd3) begin
                        we_tag    = 1'b1;
                        state_nxt = COMMIT;
                    end
                end
            end
            COMMIT: begin
                Done      = 1'b1;
                state_nxt = IDLE;
                if (req_rd) begin
                    DataOut = arr_rdata;
                end else begin
                    we_data   = 1'b1;
                    set_dirty = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Clearing ret_vld on reset drops any reads still in flight in main memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ret_vld <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ret_vld <= {ret_vld[MEM_LAT-2:0], mem_rd};
        end
    end

    always_ff @(posedge clk) begin
        ret_word <= {ret_word[MEM_LAT-2:0], cnt[WORD_W-1:0]};
        if (latch_req) begin
            req_addr <= Addr[15:1];
            req_data <= DataIn;
            req_rd   <= Rd;
        end
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: directed vector table, reset-during-fill sequence, and random
// accesses checked against a transparent-memory plus tag-state reference.
module tb_dm_cache_ctrl;
    import dm_cache_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr, DataIn, DataOut, mem_addr, mem_wdata, mem_rdata;
    logic        Rd, Wr, createdump, Done, Stall, CacheHit, err;
    logic        mem_rd, mem_wr, mem_createdump;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dm_cache_ctrl dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall),
        .CacheHit(CacheHit), .err(err), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_createdump(mem_createdump)
    );

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 257) ^ 16'h5A3C;
    endfunction

    // Main memory: fixed MEM_LAT=2 read latency, one word op per cycle, bench poke port.
    logic [15:0] mem [32768];
    logic        mem_ready = 1'b0;
    logic        rq0_v = 1'b0, rq1_v = 1'b0;
    logic [15:0] rq0_d, rq1_d;
    logic        poke_en;
    logic [12:0] poke_line;
    logic [15:0] poke_data [4];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < 32768; k++) mem[k] <= pat(k);
            mem_ready <= 1'b1;
        end else begin
            if (mem_wr) mem[mem_addr[15:1]] <= mem_wdata;
            if (poke_en) for (int k = 0; k < 4; k++) mem[{poke_line, 2'(k)}] <= poke_data[k];
        end
        rq0_v <= mem_rd;
        rq0_d <= mem[mem_addr[15:1]];
        rq1_v <= rq0_v;
        rq1_d <= rq0_d;
    end
    assign mem_rdata = rq1_v ? rq1_d : 16'hDEAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, " Done"}, Done, 0);
        check({name, " Stall"}, Stall, 0);
        check({name, " CacheHit"}, CacheHit, 0);
        check({name, " err"}, err, 0);
        check({name, " mem_rd"}, mem_rd, 0);
        check({name, " mem_wr"}, mem_wr, 0);
        check({name, " mem_addr"}, mem_addr, 0);
        check({name, " DataOut"}, DataOut, 0);
    endtask

    int          got_lat;
    logic [15:0] got_dout;
    logic        got_hit, got_err, got_stall_bad;
    logic [15:0] rd_q[$], wr_q[$], wd_q[$];

    // Called just after a rising edge; returns just after the edge that ends the Done cycle,
    // leaving the request asserted so the next call is back-to-back.
    task automatic access(input logic rd_i, input logic wr_i, input logic [15:0] a,
                          input logic [15:0] d);
        Rd = rd_i; Wr = wr_i; Addr = a; DataIn = d;
        got_lat = -1; got_dout = 0; got_hit = 0; got_err = 0; got_stall_bad = 0;
        rd_q.delete(); wr_q.delete(); wd_q.delete();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_rd) rd_q.push_back(mem_addr);
            if (mem_wr) begin
                wr_q.push_back(mem_addr);
                wd_q.push_back(mem_wdata);
            end
            if (Done) begin
                got_lat = c; got_dout = DataOut; got_hit = CacheHit; got_err = err;
                if (Stall) got_stall_bad = 1;
                break;
            end
            if (!Stall) got_stall_bad = 1;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic rd, wr; logic [15:0] addr, data; int lat; logic hit, er; logic [15:0] dout;
        int nrd, nwr; logic [15:0] ra0, wa0, wd0;
    } vec_t;
    vec_t tbl[13];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] a,
                                input logic [15:0] d, input int lat, input logic hit,
                                input logic er, input logic [15:0] dout, input int nrd,
                                input int nwr, input logic [15:0] ra0, input logic [15:0] wa0,
                                input logic [15:0] wd0);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.data = d; v.lat = lat; v.hit = hit; v.er = er;
        v.dout = dout; v.nrd = nrd; v.nwr = nwr; v.ra0 = ra0; v.wa0 = wa0; v.wd0 = wd0;
        return v;
    endfunction

    logic [15:0] golden [32768];
    logic [7:0]  r_tag   [32];
    logic        r_valid [32];
    logic        r_dirty [32];

    initial begin
        logic [7:0]  tagv;
        logic [4:0]  idx;
        logic [1:0]  w;
        logic [15:0] a, d, e_dout;
        logic        rd_i, wr_i, bad, hit;
        int          e_lat, e_nrd, e_nwr, k;

        rst = 1'b1; Rd = 0; Wr = 0; Addr = 0; DataIn = 0; createdump = 0;
        poke_en = 0; poke_line = 0;
        for (int i = 0; i < 4; i++) poke_data[i] = 16'hF000 + 16'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_quiet("norequest");
        createdump = 1'b1;
        #1 check("createdump pass", mem_createdump, 1);
        createdump = 1'b0;
        @(posedge clk); #1;

        tbl[0]  = mk(1, 0, 16'h0010, 16'h0,     7, 0, 0, pat(8),      4, 0, 16'h0010, 0, 0);
        tbl[1]  = mk(1, 0, 16'h0012, 16'h0,     0, 1, 0, pat(9),      0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 16'h0010, 16'hBEEF,  0, 1, 0, 16'h0,       0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 0, 16'h1010, 16'h0,    11, 0, 0, pat(16'h808), 4, 4, 16'h1010, 16'h0010, 16'hBEEF);
        tbl[4]  = mk(1, 0, 16'h0011, 16'h0,     0, 0, 1, 16'h0,       0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 1, 16'h0012, 16'h0,     0, 0, 1, 16'h0,       0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 16'h1012, 16'h0,     0, 1, 0, pat(16'h809), 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 16'h2040, 16'h1234,  7, 0, 0, 16'h0,       4, 0, 16'h2040, 0, 0);
        tbl[8]  = mk(1, 0, 16'h2040, 16'h0,     0, 1, 0, 16'h1234,    0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 0, 16'h2046, 16'h0,     0, 1, 0, pat(16'h1023), 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 0, 16'h0010, 16'h0,     7, 0, 0, 16'hBEEF,    4, 0, 16'h0010, 0, 0);
        tbl[11] = mk(0, 1, 16'h3040, 16'h5555, 11, 0, 0, 16'h0,       4, 4, 16'h3040, 16'h2040, 16'h1234);
        tbl[12] = mk(1, 0, 16'h2040, 16'h0,    11, 0, 0, 16'h1234,    4, 4, 16'h2040, 16'h3040, 16'h5555);

        foreach (tbl[i]) begin
            access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data);
            check($sformatf("t%0d latency", i), got_lat, tbl[i].lat);
            check($sformatf("t%0d CacheHit", i), got_hit, tbl[i].hit);
            check($sformatf("t%0d err", i), got_err, tbl[i].er);
            check($sformatf("t%0d stall", i), got_stall_bad, 0);
            if (tbl[i].rd && !tbl[i].er) check($sformatf("t%0d DataOut", i), got_dout, tbl[i].dout);
            check($sformatf("t%0d nrd", i), rd_q.size(), tbl[i].nrd);
            check($sformatf("t%0d nwr", i), wr_q.size(), tbl[i].nwr);
            if (tbl[i].nrd > 0 && rd_q.size() > 0) check($sformatf("t%0d rd addr0", i), rd_q[0], tbl[i].ra0);
            if (tbl[i].nwr > 0 && wr_q.size() > 0) begin
                check($sformatf("t%0d wr addr0", i), wr_q[0], tbl[i].wa0);
                check($sformatf("t%0d wr data0", i), wd_q[0], tbl[i].wd0);
            end
        end

        // Reset in cycle 3 of a fill of 0x0030; memory behind 0x0010 changes during reset.
        Rd = 1; Wr = 0; Addr = 16'h0030;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; Rd = 0;
        poke_en = 1; poke_line = 13'h2;
        @(negedge clk);
        check_quiet("midfill reset");
        @(posedge clk); #1;
        rst = 1'b0; poke_en = 0;
        access(1, 0, 16'h0010, 0);
        check("postrst miss latency", got_lat, 7);
        check("postrst miss hit", got_hit, 0);
        check("postrst fresh data", got_dout, 16'hF000);
        access(1, 0, 16'h0016, 0);
        check("postrst hit latency", got_lat, 0);
        check("postrst hit data", got_dout, 16'hF003);
        access(1, 0, 16'h0030, 0);
        check("aborted line miss", got_lat, 7);
        check("aborted line data", got_dout, pat(16'h18));

        // Random phase from a clean reset.
        Rd = 0; Wr = 0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 32768; i++) golden[i] = mem[i];
        for (int i = 0; i < 32; i++) begin r_valid[i] = 0; r_dirty[i] = 0; r_tag[i] = 0; end
        for (int n = 0; n < 300; n++) begin
            tagv = 8'($urandom_range(0, 3));
            idx  = 5'($urandom_range(0, 3));
            w    = 2'($urandom_range(0, 3));
            a    = {tagv, idx, w, 1'b0};
            d    = 16'($urandom);
            rd_i = 1'($urandom_range(0, 1));
            wr_i = !rd_i;
            k    = $urandom_range(0, 15);
            if (k == 0) a[0] = 1'b1;
            if (k == 1) begin rd_i = 1; wr_i = 1; end
            bad = a[0] || (rd_i && wr_i);
            hit = r_valid[idx] && (r_tag[idx] == tagv);
            e_nwr = (!bad && !hit && r_valid[idx] && r_dirty[idx]) ? 4 : 0;
            e_nrd = (!bad && !hit) ? 4 : 0;
            e_lat = (bad || hit) ? 0 : ((e_nwr != 0) ? 11 : 7);
            e_dout = golden[a[15:1]];
            access(rd_i, wr_i, a, d);
            check($sformatf("r%0d latency", n), got_lat, e_lat);
            check($sformatf("r%0d CacheHit", n), got_hit, !bad && hit);
            check($sformatf("r%0d err", n), got_err, bad);
            check($sformatf("r%0d stall", n), got_stall_bad, 0);
            if (rd_i && !bad) check($sformatf("r%0d DataOut", n), got_dout, e_dout);
            check($sformatf("r%0d nrd", n), rd_q.size(), e_nrd);
            check($sformatf("r%0d nwr", n), wr_q.size(), e_nwr);
            for (int j = 0; j < 4; j++) begin
                if (j < rd_q.size()) check($sformatf("r%0d rd addr%0d", n, j), rd_q[j], {tagv, idx, 2'(j), 1'b0});
                if (j < wr_q.size()) begin
                    check($sformatf("r%0d wr addr%0d", n, j), wr_q[j], {r_tag[idx], idx, 2'(j), 1'b0});
                    check($sformatf("r%0d wr data%0d", n, j), wd_q[j], golden[{r_tag[idx], idx, 2'(j)}]);
                end
            end
            if (!bad) begin
                if (!hit) begin
                    r_valid[idx] = 1; r_tag[idx] = tagv; r_dirty[idx] = 0;
                end
                if (wr_i) begin
                    r_dirty[idx] = 1;
                    golden[a[15:1]] = d;
                end
            end
        end
        Rd = 0; Wr = 0;
        @(negedge clk);
        check_quiet("final idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dm_cache_ctrl.md
# dm_cache_ctrl

Direct-mapped, write-back, write-allocate cache controller that is the responder side of the stalling memory interface used by the fetch and memory stages. It accepts one 16-bit word access at a time from a pipeline stage, answers hits in the same cycle, and stalls the requester while it services misses against a fixed-latency, word-wide main memory. It replaces the always-ready instruction/data memory behind each pipeline port.

## Interface
- LINES, 32: number of cache lines; index width = log2(LINES) = 5.
- WORDS, 4: 16-bit words per line; byte-offset width = 3.
- MEM_LAT, 2: cycles from a main-memory read issue to its read data.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- Addr  in  16  byte address; bit 0 must be 0.
- DataIn  in  16  write data.
- Rd, Wr  in  1  read / write request; at most one high.
- createdump  in  1  ignored by this block; passed through to main memory.
- DataOut  out  16  read data, valid while Done=1 and Rd=1.
- Done  out  1  access complete this cycle.
- Stall  out  1  requester must hold Addr/DataIn/Rd/Wr stable.
- CacheHit  out  1  qualifies Done: 1 = hit, 0 = miss service.
- err  out  1  illegal request this cycle.
- mem_addr  out  16  word-aligned main-memory address.
- mem_rd, mem_wr  out  1  one main-memory word op per cycle.
- mem_wdata  out  16  write-back data.
- mem_rdata  in  16  read data, valid exactly MEM_LAT cycles after mem_rd.

## Operation
- Address split: tag = Addr[15:8], index = Addr[7:3], word = Addr[2:1].
- States: IDLE, WB, FILL, COMMIT.
- IDLE, request with valid & tag match: hit. Read drives DataOut combinationally; write updates word, sets dirty. Done=1, CacheHit=1, Stall=0, same cycle.
- IDLE, miss, line clean or invalid: Stall=1, go to FILL.
- IDLE, miss, line valid & dirty: Stall=1, go to WB.
- WB: four consecutive cycles issue mem_wr for words 0..3 of victim at {old tag, index, word, 1'b0}; then FILL.
- FILL: four consecutive cycles issue mem_rd for words 0..3 of the new line; each return captured into the data array at its word slot; after the last return, write tag, valid=1, dirty=0, go to COMMIT.
- COMMIT: perform original access on the filled line (write sets dirty); Done=1, CacheHit=0, Stall=0; return to IDLE.
- Stall=1 in every cycle of a miss from request cycle through the cycle before COMMIT.
- err: Addr[0]=1 with Rd or Wr, or Rd&Wr both high → err=1, Done=1, Stall=0, no state or array change; only evaluated in IDLE.
- No request (Rd=Wr=0): all of Done, Stall, CacheHit, err = 0.

## Timing
- Reset values: state IDLE, all valid and dirty bits 0, DataOut 0, Done/Stall/CacheHit/err 0, mem_rd/mem_wr 0, mem_addr 0.
- Hit latency 0 cycles (combinational Done).
- Clean miss, request cycle 0: reads issued cycles 1–4, last data cycle 4+MEM_LAT, COMMIT/Done cycle 5+MEM_LAT (7 at default).
- Dirty miss: writes cycles 1–4, reads 5–8, Done cycle 9+MEM_LAT (11 at default).
- Requester changing inputs while Stall=1 is illegal; controller uses latched request fields, not live inputs, during miss service.
- Reset mid-miss: FSM to IDLE, all lines invalidated; a return-tracking shift register (MEM_LAT deep) is cleared so memory data returned after reset is discarded.
- Back-to-back: new request accepted the cycle after COMMIT.

## Structure
- Shared package/include cache_defs: LINES, WORDS, MEM_LAT defaults, field widths, state encodings (2-bit).
- Sub-module cache_array: tag/valid/dirty/data storage, asynchronous read, synchronous write, async clear of valid/dirty on rst. Controller FSM, request latch, word counter and return tracker live in dm_cache_ctrl.

## Test plan
- Reset, Rd Addr 0x0010 → Stall for 7 cycles, mem_rd to 0x0010,0x0012,0x0014,0x0016, Done=1 CacheHit=0 at cycle 7 with memory word.
- Repeat Rd 0x0012 → Done=1, CacheHit=1, same cycle, no mem_rd.
- Wr 0x0010 data 0xBEEF (hit), then Rd 0x1010 (same index, new tag) → writeback 4 words incl. 0xBEEF to 0x0010.., then fill; Done at cycle 11.
- Rd Addr 0x0011 → err=1, Done=1, no mem activity, no state change.
- Assert rst at cycle 3 of a fill → outputs at reset values; following Rd 0x0010 misses and fetches fresh data; stale returns not written.
- Wr miss to 0x2040 data 0x1234 → fill, then COMMIT writes word; later Rd 0x2040 hits returning 0x1234.
